// File: rtl/dmem_responder_pkg.sv
// ============================================================================
// dmem_responder_pkg -- size codes and lane helpers for the data-memory responder
// Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_responder_pkg;

   localparam logic [1:0] c_size_byte = 2'b00;
   localparam logic [1:0] c_size_half = 2'b01;
   localparam logic [1:0] c_size_word = 2'b10;
   localparam logic [1:0] c_size_rsvd = 2'b11;

   // Replace only the addressed lane(s) of word with the right-aligned wdata.
   function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  ln);
      logic [31:0] mask;
      logic [31:0] data;
      logic [4:0]  sh;
      mask = 32'hFFFF_FFFF;
      data = wdata;
      sh   = 5'd0;
      case (size)
         c_size_byte: begin
            sh   = {ln, 3'b000};
            mask = 32'h0000_00FF << sh;
            data = {24'h0, wdata[7:0]} << sh;
         end
         c_size_half: begin
            sh   = {ln[1], 4'b0000};
            mask = 32'h0000_FFFF << sh;
            data = {16'h0, wdata[15:0]} << sh;
         end
         default: begin
            mask = 32'hFFFF_FFFF;
            data = wdata;
         end
      endcase
      return (word & ~mask) | (data & mask);
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                input logic [1:0]  size,
                                                input logic [1:0]  ln,
                                                input logic        rdun);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (ln)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = ln[1] ? word[31:16] : word[15:0];
      case (size)
         c_size_byte: res = rdun ? {24'h0, b} : {{24{b[7]}}, b};
         c_size_half: res = rdun ? {16'h0, h} : {{16{h[15]}}, h};
         default:     res = word;
      endcase
      return res;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_sram.sv
// ============================================================================
// dmem_sram -- single-port word-wide array, synchronous read and write
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_sram #(
   parameter int unsigned DEPTH_WORDS = 16384,
   parameter int unsigned ADDR_W      = 14
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] r_mem [DEPTH_WORDS];

   // Read data holds while en is low, so a read-modify-write can reuse it.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            r_mem[addr] <= wdata;
         end else begin
            rdata <= r_mem[addr];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder -- load/store target for the memory stage: handshake FSM,
// sub-word read-modify-write, load extension and access error detection
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 16384,
   parameter logic [31:0] BASE_ADDR   = 32'h0100_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_rdun,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned c_aw   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [32:0] c_span = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_WRITE   = 3'd2,
      ST_RESP    = 3'd3,
      ST_ERR_RSP = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              r_ready;
   logic [c_aw-1:0]   r_idx;
   logic [1:0]        r_ln;
   logic [31:0]       r_wdata;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_rdun;
   logic [31:0]       r_rdata;
   logic              r_err;

   logic [31:0]       w_off;
   logic              w_accept;
   logic              w_err;
   logic              w_sram_en;
   logic              w_sram_we;
   logic [c_aw-1:0]   w_sram_addr;
   logic [31:0]       w_sram_wdata;
   logic [31:0]       w_sram_rdata;

   assign w_off    = req_addr - BASE_ADDR;
   assign w_accept = req_valid & r_ready;
   // Unsigned span check also rejects addresses below BASE_ADDR (they wrap high).
   assign w_err    = ({1'b0, w_off} >= c_span)
                   | ((req_size == c_size_half) & w_off[0])
                   | ((req_size == c_size_word) & (w_off[1:0] != 2'b00))
                   | (req_size == c_size_rsvd);

   assign req_ready = r_ready;
   assign rsp_valid = (r_state == ST_RESP) || (r_state == ST_ERR_RSP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

   always_comb begin
      w_next       = r_state;
      w_sram_en    = 1'b0;
      w_sram_we    = 1'b0;
      w_sram_addr  = r_idx;
      w_sram_wdata = lane_merge(w_sram_rdata, r_wdata, r_size, r_ln);
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if (w_err) begin
                  w_next = ST_ERR_RSP;
               end else begin
                  w_next      = ST_READ;
                  w_sram_en   = 1'b1;
                  w_sram_addr = w_off[c_aw+1:2];
               end
            end
         end
         ST_READ:  w_next = r_we ? ST_WRITE : ST_RESP;
         ST_WRITE: begin
            w_sram_en = 1'b1;
            w_sram_we = 1'b1;
            w_next    = ST_RESP;
         end
         ST_RESP, ST_ERR_RSP: begin
            if (rsp_ready) begin
               w_next = ST_IDLE;
            end
         end
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ready <= 1'b0;
         r_idx   <= '0;
         r_ln    <= 2'b00;
         r_wdata <= 32'h0;
         r_we    <= 1'b0;
         r_size  <= 2'b00;
         r_rdun  <= 1'b0;
         r_rdata <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ready <= (w_next == ST_IDLE);
         if ((r_state == ST_IDLE) && w_accept) begin
            r_idx   <= w_off[c_aw+1:2];
            r_ln    <= w_off[1:0];
            r_wdata <= req_wdata;
            r_we    <= req_we;
            r_size  <= req_size;
            r_rdun  <= req_rdun;
            r_rdata <= 32'h0;
            r_err   <= w_err;
         end
         if ((r_state == ST_READ) && !r_we) begin
            r_rdata <= load_extract(w_sram_rdata, r_size, r_ln, r_rdun);
         end
      end
   end

   dmem_sram #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .ADDR_W      (c_aw)
   ) u_sram (
      .clk   (clk),
      .en    (w_sram_en),
      .we    (w_sram_we),
      .addr  (w_sram_addr),
      .wdata (w_sram_wdata),
      .rdata (w_sram_rdata)
   );

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder -- vector table plus hand sequences, scoreboarded responses
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_responder;
   import dmem_responder_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_rdun = 1'b0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          due;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic [1:0]  size;
      logic        rdun;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;
   vec_t vecs[$];

   dmem_responder dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_rdun  (req_rdun),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   // Response monitor: first-valid cycle checks latency, handshake pops and checks data.
   bit seen = 1'b0;
   always @(negedge clk) begin
      if (rst_n && rsp_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
         end else begin
            if (!seen) begin
               chk("rsp_latency", cyc, sb[0].due);
               seen = 1'b1;
            end
            if (rsp_ready) begin
               chk("rsp_rdata", rsp_rdata, sb[0].rdata);
               chk("rsp_err", {31'b0, rsp_err}, {31'b0, sb[0].err});
               void'(sb.pop_front());
               seen = 1'b0;
            end
         end
      end
   end

   task automatic drive(input vec_t v);
      req_addr  = v.addr;
      req_wdata = v.wdata;
      req_we    = v.we;
      req_size  = v.size;
      req_rdun  = v.rdun;
      req_valid = 1'b1;
   endtask

   task automatic send(input vec_t v);
      int n;
      int lat;
      lat = v.exp_err ? 1 : (v.we ? 3 : 2);
      @(posedge clk); #1;
      drive(v);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!req_ready && n < 20);
      if (!req_ready) begin
         chk("accept_timeout", {31'b0, req_ready}, 32'd1);
         req_valid = 1'b0;
         return;
      end
      sb.push_back('{v.exp_rdata, v.exp_err, cyc + lat});
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         chk("rsp_timeout", sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int   n;
      bit   quiet;

      // ---- reset
      #2 rst_n = 1'b0;
      #3;
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      chk("rst_rel_ready_low", {31'b0, req_ready}, 32'd0);
      @(posedge clk); #1;
      chk("rst_rel_ready_high", {31'b0, req_ready}, 32'd1);

      // ---- table: addr, wdata, we, size, rdun, exp_rdata, exp_err
      vecs.push_back('{32'h0100_0000, 32'h1234_5678, 1'b1, c_size_word, 1'b0, 32'h0, 1'b0});
      vecs.push_back('{32'h0100_0008, 32'hA5A5_A5A5, 1'b1, c_size_word, 1'b0, 32'h0, 1'b0});
      vecs.push_back('{32'h0100_0004, 32'hDEAD_BEEF, 1'b1, c_size_word, 1'b0, 32'h0, 1'b0});
      vecs.push_back('{32'h0100_0004, 32'h0,         1'b0, c_size_word, 1'b0, 32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{32'h0100_0005, 32'h1234_5680, 1'b1, c_size_byte, 1'b0, 32'h0, 1'b0});
      vecs.push_back('{32'h0100_0005, 32'h0,         1'b0, c_size_byte, 1'b0, 32'hFFFF_FF80, 1'b0});
      vecs.push_back('{32'h0100_0005, 32'h0,         1'b0, c_size_byte, 1'b1, 32'h0000_0080, 1'b0});
      vecs.push_back('{32'h0100_0004, 32'h0,         1'b0, c_size_word, 1'b0, 32'hDEAD_80EF, 1'b0});
      vecs.push_back('{32'h0100_0006, 32'hA5A5_8001, 1'b1, c_size_half, 1'b0, 32'h0, 1'b0});
      vecs.push_back('{32'h0100_0006, 32'h0,         1'b0, c_size_half, 1'b0, 32'hFFFF_8001, 1'b0});
      vecs.push_back('{32'h0100_0006, 32'h0,         1'b0, c_size_half, 1'b1, 32'h0000_8001, 1'b0});
      vecs.push_back('{32'h0100_0004, 32'h0,         1'b0, c_size_word, 1'b1, 32'h8001_80EF, 1'b0});
      vecs.push_back('{32'h0100_0007, 32'h0,         1'b0, c_size_byte, 1'b0, 32'hFFFF_FF80, 1'b0});
      vecs.push_back('{32'h0100_0004, 32'h0,         1'b0, c_size_byte, 1'b0, 32'hFFFF_FFEF, 1'b0});
      vecs.push_back('{32'h0100_0003, 32'h0,         1'b0, c_size_half, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{32'h0100_0002, 32'hFFFF_FFFF, 1'b1, c_size_word, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{32'h00FF_FFFC, 32'h0,         1'b0, c_size_word, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{32'h0100_0000, 32'h0,         1'b0, c_size_rsvd, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{32'h0100_0000, 32'hFFFF_FFFF, 1'b1, c_size_rsvd, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{32'h0100_0001, 32'hFFFF_FFFF, 1'b1, c_size_half, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{32'h0101_0000, 32'hFFFF_FFFF, 1'b1, c_size_byte, 1'b0, 32'h0, 1'b1});
      vecs.push_back('{32'h0100_0000, 32'h0,         1'b0, c_size_word, 1'b0, 32'h1234_5678, 1'b0});
      vecs.push_back('{32'h0100_FFFC, 32'h0,         1'b1, c_size_word, 1'b0, 32'h0, 1'b0});
      vecs.push_back('{32'h0100_FFFF, 32'h0000_007F, 1'b1, c_size_byte, 1'b0, 32'h0, 1'b0});
      vecs.push_back('{32'h0100_FFFE, 32'h0,         1'b0, c_size_half, 1'b0, 32'h0000_7F00, 1'b0});
      vecs.push_back('{32'h0100_0000, 32'h0,         1'b0, c_size_byte, 1'b1, 32'h0000_0078, 1'b0});
      vecs.push_back('{32'h0100_0002, 32'h0,         1'b0, c_size_half, 1'b0, 32'h0000_1234, 1'b0});

      foreach (vecs[i]) send(vecs[i]);

      // ---- back-pressure: hold rsp_ready low for 5 cycles on a load response
      rsp_ready = 1'b0;
      v = '{32'h0100_0004, 32'h0, 1'b0, c_size_word, 1'b0, 32'h8001_80EF, 1'b0};
      @(posedge clk); #1;
      drive(v);
      @(negedge clk);
      chk("bp_accept", {31'b0, req_ready}, 32'd1);
      sb.push_back('{v.exp_rdata, v.exp_err, cyc + 2});
      @(posedge clk); #1;
      // Competing request while busy must be ignored.
      req_addr = 32'h0100_0000;
      req_we   = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_valid && n < 10);
      for (int i = 0; i < 5; i++) begin
         chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("bp_rsp_rdata", rsp_rdata, 32'h8001_80EF);
         chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
         @(negedge clk);
      end
      req_valid = 1'b0;
      req_we    = 1'b0;
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_valid", {31'b0, rsp_valid}, 32'd0);
      chk("bp_release_ready", {31'b0, req_ready}, 32'd1);
      chk("bp_sb_empty", sb.size(), 32'd0);
      sb.delete();

      // ---- reset while a store sits in READ
      v = '{32'h0100_0008, 32'h1111_1111, 1'b1, c_size_word, 1'b0, 32'h0, 1'b0};
      @(posedge clk); #1;
      drive(v);
      @(negedge clk);
      chk("mr_accept", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      #1;
      chk("mr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("mr_req_ready", {31'b0, req_ready}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid) quiet = 1'b0;
      end
      chk("mr_no_response", {31'b0, quiet}, 32'd1);
      send('{32'h0100_0008, 32'h0, 1'b0, c_size_word, 1'b0, 32'hA5A5_A5A5, 1'b0});

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: the target side of the load/store interface driven by the memory stage. It accepts one request at a time over a valid/ready handshake. It performs byte, halfword and word accesses on a word-wide synchronous array, using read-modify-write for sub-word stores. Load data is returned sign- or zero-extended, and misaligned or out-of-range accesses are flagged.

## Interface
Parameters:
- `DEPTH_WORDS`, 16384: array depth in 32-bit words (64 KiB).
- `BASE_ADDR`, 32'h0100_0000: byte address of word 0.

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst_n`  in  1  — reset, asynchronous, active-low.
- `req_valid`  in  1  — request present.
- `req_ready`  out  1  — responder can accept a request.
- `req_addr`  in  32  — byte address.
- `req_wdata`  in  32  — store data, right-aligned (value is in the low bytes).
- `req_we`  in  1  — 1 = store, 0 = load.
- `req_size`  in  2  — `` `BYTE ``=00, `` `HALFWORD ``=01, `` `WORD ``=10; 11 is reserved.
- `req_rdun`  in  1  — 1 = zero-extend load data, 0 = sign-extend.
- `rsp_valid`  out  1  — response present.
- `rsp_ready`  in  1  — consumer accepts the response.
- `rsp_rdata`  out  32  — extended load data; 0 for stores and errors.
- `rsp_err`  out  1  — the access was misaligned, out of range, or used the reserved size.

## Operation
- A request is accepted when `req_valid & req_ready`. At accept, addr/wdata/we/size/rdun are captured into registers.
- `off = req_addr - BASE_ADDR`; word index `idx = off[31:2]`; byte lane `ln = off[1:0]`. Little-endian.
- Error conditions:
  - `off >= 4*DEPTH_WORDS` (unsigned compare, so addresses below `BASE_ADDR` wrap and fail);
  - halfword access with `ln[0]=1`;
  - word access with `ln!=0`;
  - `req_size=11`.
- An errored request performs no array write.
- States and transitions:
  - IDLE: `req_ready=1`. On accept, go to ERR_RSP if an error condition holds, otherwise go to READ and issue the array read of `idx`.
  - READ: the array word is now registered. A load goes to RESP with extracted data. A store goes to WRITE.
  - WRITE: merge only the addressed lane(s) of the registered word with `wdata` (byte → lane `ln`, halfword → lanes `ln[1]*2+{0,1}`, word → all lanes), write the result to `idx`, then go to RESP.
  - ERR_RSP / RESP: `rsp_valid=1` and the outputs are held stable until `rsp_ready`; then return to IDLE.
- Load extraction: select byte `word >> 8*ln` or halfword `word >> 16*ln[1]`, then sign- or zero-extend per `rdun`. For word loads `rdun` is ignored.
- `req_ready` is 0 in every state except IDLE. There is no accept in the same cycle as the response handshake.

## Timing
- Reset (`rst_n` low, asynchronous): state=IDLE, `rsp_valid=0`, `rsp_rdata=0`, `rsp_err=0`. `req_ready=0` while `rst_n` is low and 1 from the first edge after release. Array contents are not reset.
- With accept at edge T:
  - load: `rsp_valid` rises after T+2;
  - store: `rsp_valid` rises after T+3, and the array write occurs at edge T+2;
  - error: `rsp_valid` rises after T+1.
- If `rsp_ready` is held high, the responder returns to IDLE one edge after `rsp_valid` rises. Minimum request spacing: 3 cycles for a load, 4 for a store, 2 for an error.
- Reset mid-transaction drops the transaction, with no response. A store write already done at T+2 remains; one not yet done never happens.
- Request inputs are ignored outside IDLE. The response outputs do not change while `rsp_valid & !rsp_ready`.

## Structure
- The shared defines header holds the `` `BYTE ``/`` `HALFWORD ``/`` `WORD `` size codes and the `` `LCC ``/`` `SCC `` opcodes already used by the core. State encodings stay local to this block.
- One sub-module: `dmem_sram` — a single-port, word-wide, synchronous-read, synchronous-write array with parameter `DEPTH_WORDS`. The FSM, lane merge and extension logic live in `dmem_responder`.

## Test plan
- Word store 32'hDEADBEEF to 0x01000004, then word load 0x01000004 → `rsp_rdata`=32'hDEADBEEF, `rsp_err`=0; load response after T+2, store response after T+3.
- After that, byte store 8'h80 to 0x01000005; signed byte load 0x01000005 → 32'hFFFFFF80; unsigned byte load → 32'h00000080; word load → 32'hDEAD80EF.
- Halfword store 16'h8001 to 0x01000006; signed halfword load → 32'hFFFF8001; unsigned halfword load → 32'h00008001; word load → 32'h800180EF.
- Halfword load at 0x01000003, word store at 0x01000002, load at 0x00FFFFFC, and `req_size`=11 → each gives `rsp_err`=1 with `rsp_rdata`=0 after T+1, and the following word load of 0x01000000 shows no change to the array.
- Hold `rsp_ready`=0 for 5 cycles during a load response → `rsp_valid`/`rsp_rdata` are stable and `req_ready`=0 throughout; raise `rsp_ready` → IDLE on the next edge.
- Assert `rst_n` low in the cycle after accepting a store (state READ) → `rsp_valid`=0 immediately, no response is produced, and a later load of that address returns the old contents.
